// File: rtl/mem_readback_unit.sv
// mem_readback_unit: walks MEM16x8 one entry at a time for display.
// Debounced next/prev buttons step a wrapping 4-bit address. Each step
// re-fetches the entry through a registered read of READ_LATENCY cycles.
//
// Handshake: value_valid high means value == MEM[value_addr] as captured at
// the end of the fetch. value_valid drops as soon as a new fetch starts and
// stays low until that fetch completes. busy is high exactly while a fetch is
// in progress. No ready/back-pressure exists; the display just samples.
module mem_readback_unit #(
  parameter int READ_LATENCY    = 1,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       btn_next,
  input  logic       btn_prev,
  input  logic [7:0] mem_data,
  output logic [3:0] mem_addr,
  output logic [7:0] value,
  output logic [3:0] value_addr,
  output logic       value_valid,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    SHOW  = 2'd3
  } state_t;

  // Bit 0 is the next button, bit 1 the prev button.
  logic [1:0] raw;
  logic [1:0] press;

  assign raw = {btn_prev, btn_next};

  for (genvar g = 0; g < 2; g++) begin : g_btn
    logic             sync1;
    logic             sync2;
    logic             stable;
    logic             pulse;
    logic [CNT_W-1:0] cnt;

    // Two-flop synchronizer, then a counter that accepts a new level only
    // after it has persisted for DEBOUNCE_CYCLES consecutive cycles. The
    // press pulse fires on the same edge the stable level rises.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sync1  <= 1'b0;
        sync2  <= 1'b0;
        stable <= 1'b0;
        pulse  <= 1'b0;
        cnt    <= '0;
      end else begin
        sync1 <= raw[g];
        sync2 <= sync1;
        pulse <= 1'b0;
        if (sync2 == stable) begin
          cnt <= '0;
        end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          stable <= sync2;
          pulse  <= sync2;
          cnt    <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end

    assign press[g] = pulse;
  end

  state_t     state_q, state_d;
  logic [3:0] cur_q, cur_d;
  logic [3:0] maddr_q, maddr_d;
  logic [7:0] val_q, val_d;
  logic [3:0] vaddr_q, vaddr_d;
  logic       vvalid_q, vvalid_d;
  logic [1:0] wcnt_q, wcnt_d;
  logic       en_d;
  logic       en_rise;

  assign en_rise = enable & ~en_d;

  // Remember last cycle's enable so a fresh grant is seen as a single edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) en_d <= 1'b0;
    else     en_d <= enable;
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cur_q    <= '0;
      maddr_q  <= '0;
      val_q    <= '0;
      vaddr_q  <= '0;
      vvalid_q <= 1'b0;
      wcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      maddr_q  <= maddr_d;
      val_q    <= val_d;
      vaddr_q  <= vaddr_d;
      vvalid_q <= vvalid_d;
      wcnt_q   <= wcnt_d;
    end
  end

  // Next-state and datapath decisions. Losing enable wins over everything:
  // any fetch in flight is abandoned and the display is blanked.
  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    maddr_d  = maddr_q;
    val_d    = val_q;
    vaddr_d  = vaddr_q;
    vvalid_d = vvalid_q;
    wcnt_d   = wcnt_q;
    if (state_q != IDLE && !enable) begin
      state_d  = IDLE;
      vvalid_d = 1'b0;
      val_d    = '0;
      vaddr_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          vvalid_d = 1'b0;
          if (en_rise) begin
            cur_d   = '0;
            maddr_d = '0;
            state_d = ISSUE;
          end
        end
        ISSUE: begin
          wcnt_d  = 2'(READ_LATENCY - 1);
          state_d = WAIT;
        end
        WAIT: begin
          if (wcnt_q == 2'd0) begin
            val_d    = mem_data;
            vaddr_d  = maddr_q;
            vvalid_d = 1'b1;
            state_d  = SHOW;
          end else begin
            wcnt_d = wcnt_q - 2'd1;
          end
        end
        SHOW: begin
          // Simultaneous next and prev cancel each other out.
          if (press[0] && !press[1]) begin
            cur_d    = cur_q + 4'd1;
            maddr_d  = cur_q + 4'd1;
            vvalid_d = 1'b0;
            state_d  = ISSUE;
          end else if (press[1] && !press[0]) begin
            cur_d    = cur_q - 4'd1;
            maddr_d  = cur_q - 4'd1;
            vvalid_d = 1'b0;
            state_d  = ISSUE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign mem_addr    = maddr_q;
  assign value       = val_q;
  assign value_addr  = vaddr_q;
  assign value_valid = vvalid_q;
  assign busy        = (state_q == ISSUE) || (state_q == WAIT);

endmodule

// File: tb/tb_mem_readback_unit.sv
// Bench for mem_readback_unit: 1-cycle registered memory with MEM[i]=8'h10+i,
// short debounce, directed boundary cases plus randomized button traffic.
module tb_mem_readback_unit;

  localparam int RL = 1;
  localparam int DB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       btn_next = 1'b0;
  logic       btn_prev = 1'b0;
  logic [7:0] mem_data = 8'h00;
  logic [3:0] mem_addr;
  logic [7:0] value;
  logic [3:0] value_addr;
  logic       value_valid;
  logic       busy;

  int tests_run = 0;
  int failures  = 0;
  int model_addr = 0;
  int busy_cnt = 0;
  logic prev_valid = 1'b0;
  logic [3:0] exp_q[$];

  mem_readback_unit #(
    .READ_LATENCY(RL),
    .DEBOUNCE_CYCLES(DB),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .btn_next(btn_next),
    .btn_prev(btn_prev),
    .mem_data(mem_data),
    .mem_addr(mem_addr),
    .value(value),
    .value_addr(value_addr),
    .value_valid(value_valid),
    .busy(busy)
  );

  // Clock and memory model.
  always #5 clk = ~clk;

  always @(posedge clk) mem_data <= 8'h10 + {4'h0, mem_addr};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every completed fetch must match the oldest expected address.
  always @(negedge clk) begin
    if (busy) busy_cnt++;
    if (value_valid && !prev_valid && !rst) begin
      if (exp_q.size() == 0) begin
        check("extra_capture", 32'd1, 32'd0);
      end else begin
        logic [3:0] e;
        e = exp_q.pop_front();
        check("cap_addr", {28'd0, value_addr}, {28'd0, e});
        check("cap_value", {24'd0, value}, {24'd0, 8'h10 + {4'h0, e}});
      end
    end
    prev_valid = value_valid;
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic wait_valid(input string tag);
    int k;
    k = 0;
    while (!value_valid && k < 40) begin
      @(negedge clk);
      k++;
    end
    check(tag, {31'd0, value_valid}, 32'd1);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_addr"}, {28'd0, mem_addr}, 32'd0);
    check({tag, "_value"}, {24'd0, value}, 32'd0);
    check({tag, "_vaddr"}, {28'd0, value_addr}, 32'd0);
    check({tag, "_valid"}, {31'd0, value_valid}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  // Hold the buttons for 'hold' cycles, release, let everything settle, then
  // compare against the model: a step happens only for a lone button held at
  // least DB cycles.
  task automatic press(input logic nx, input logic pv, input int hold);
    logic step;
    step = (nx ^ pv) && (hold >= DB);
    if (step) begin
      model_addr = (model_addr + (nx ? 1 : 15)) % 16;
      exp_q.push_back(4'(model_addr));
    end
    busy_cnt = 0;
    btn_next = nx;
    btn_prev = pv;
    tick(hold);
    btn_next = 1'b0;
    btn_prev = 1'b0;
    tick(14);
    wait_valid("press_settle");
    check("press_busy_cycles", 32'(busy_cnt), step ? 32'(RL + 1) : 32'd0);
    check("press_vaddr", {28'd0, value_addr}, 32'(model_addr));
    check("press_value", {24'd0, value}, 32'(8'h10 + model_addr));
  endtask

  initial begin
    int bc;
    int k;

    // Reset takes effect without any clock edge.
    #3;
    check_outputs_zero("reset");
    tick(2);
    rst = 1'b0;
    tick(2);
    check_outputs_zero("idle");

    // Enable: valid three cycles later, busy for two of them.
    enable = 1'b1;
    model_addr = 0;
    exp_q.push_back(4'd0);
    bc = 0;
    tick(1); bc += busy;
    tick(1); bc += busy;
    check("en_valid_early", {31'd0, value_valid}, 32'd0);
    tick(1); bc += busy;
    check("en_valid_3", {31'd0, value_valid}, 32'd1);
    check("en_busy_cycles", 32'(bc), 32'(RL + 1));
    check("en_vaddr", {28'd0, value_addr}, 32'd0);
    check("en_value", {24'd0, value}, 32'h10);

    // Long holds step exactly once each.
    for (int i = 0; i < 3; i++) press(1'b1, 1'b0, 10);
    for (int i = 0; i < 3; i++) press(1'b0, 1'b1, 10);
    // Wrap both ways.
    press(1'b0, 1'b1, 10);
    press(1'b1, 1'b0, 10);

    // Glitch and simultaneous presses are filtered.
    press(1'b1, 1'b0, DB - 1);
    press(1'b1, 1'b1, 10);

    // A prev press landing while the next-fetch is in progress is dropped.
    busy_cnt = 0;
    model_addr = (model_addr + 1) % 16;
    exp_q.push_back(4'(model_addr));
    btn_next = 1'b1;
    tick(1);
    btn_prev = 1'b1;
    tick(10);
    btn_next = 1'b0;
    btn_prev = 1'b0;
    tick(14);
    wait_valid("busy_drop_settle");
    check("busy_drop_cycles", 32'(busy_cnt), 32'(RL + 1));
    check("busy_drop_vaddr", {28'd0, value_addr}, 32'(model_addr));

    // Randomized button traffic.
    for (int i = 0; i < 24; i++) begin
      int sel;
      sel = $urandom_range(0, 3);
      press(sel == 3 || sel < 2, sel >= 2, $urandom_range(1, 12));
    end

    // Drop enable while a fetch is in flight.
    btn_next = 1'b1;
    k = 0;
    while (!busy && k < 30) begin
      tick(1);
      k++;
    end
    check("drop_saw_busy", {31'd0, busy}, 32'd1);
    enable = 1'b0;
    tick(1);
    check("drop_valid", {31'd0, value_valid}, 32'd0);
    check("drop_value", {24'd0, value}, 32'd0);
    check("drop_vaddr", {28'd0, value_addr}, 32'd0);
    check("drop_busy", {31'd0, busy}, 32'd0);
    btn_next = 1'b0;
    tick(14);
    check("drop_no_capture", {31'd0, value_valid}, 32'd0);

    // Re-enable restarts at address 0.
    enable = 1'b1;
    model_addr = 0;
    exp_q.push_back(4'd0);
    tick(1);
    wait_valid("reen_settle");
    check("reen_vaddr", {28'd0, value_addr}, 32'd0);
    check("reen_value", {24'd0, value}, 32'h10);

    // Asynchronous reset while showing address 5.
    for (int i = 0; i < 5; i++) press(1'b1, 1'b0, 8);
    check("pre_rst_vaddr", {28'd0, value_addr}, 32'd5);
    #2 rst = 1'b1;
    #1;
    check_outputs_zero("async_rst");
    enable = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(1);
    enable = 1'b1;
    model_addr = 0;
    exp_q.push_back(4'd0);
    tick(1);
    wait_valid("post_rst_settle");
    check("post_rst_vaddr", {28'd0, value_addr}, 32'd0);
    check("post_rst_value", {24'd0, value}, 32'h10);

    tick(2);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
